// File: rtl/assoc_cache_ctrl_if.sv
// rtl/assoc_cache_ctrl_if.sv - CPU, flush and memory-side signal bundle for assoc_cache_ctrl
// Stats outputs exist only when ASSOC_CACHE_STATS_EN is defined.
interface assoc_cache_ctrl_if #(
  parameter int BLK_W = 128
);
  logic [31:0]      cpu_req_addr;
  logic [31:0]      cpu_req_datain;
  logic             cpu_req_rw;
  logic             cpu_req_valid;
  logic [31:0]      cpu_req_dataout;
  logic             cache_ready;
  logic             flush_req;
  logic             flush_done;
  logic [31:0]      mem_req_addr;
  logic [BLK_W-1:0] mem_req_dataout;
  logic [BLK_W-1:0] mem_req_datain;
  logic             mem_req_rw;
  logic             mem_req_valid;
  logic             mem_req_ready;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0]      stat_hits;
  logic [31:0]      stat_misses;
  logic [31:0]      stat_writebacks;
`endif

  modport slave (
    input  cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid, flush_req,
    input  mem_req_datain, mem_req_ready,
    output cpu_req_dataout, cache_ready, flush_done,
    output mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid
`ifdef ASSOC_CACHE_STATS_EN
    , output stat_hits, stat_misses, stat_writebacks
`endif
  );

  modport master (
    output cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid, flush_req,
    output mem_req_datain, mem_req_ready,
    input  cpu_req_dataout, cache_ready, flush_done,
    input  mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid
`ifdef ASSOC_CACHE_STATS_EN
    , input stat_hits, stat_misses, stat_writebacks
`endif
  );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// rtl/assoc_cache_ctrl.sv - N-way write-back/write-allocate cache controller, true LRU, flush sequencer
// Optional hit/miss/write-back counters under ASSOC_CACHE_STATS_EN.
module assoc_cache_ctrl #(
  parameter int WAYS      = 4,
  parameter int SETS      = 512,
  parameter int BLK_WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  assoc_cache_ctrl_if.slave  bus
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WRD_W  = $clog2(BLK_WORDS);
  localparam int OFF_W  = WRD_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int BLK_W  = 32 * BLK_WORDS;
  localparam int LINE_W = IDX_W + WAY_W;

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_WRITE_BACK, S_ALLOCATE, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  state_t state, state_n;

  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [BLK_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]  valid    [SETS];
  logic [WAYS-1:0]  dirty    [SETS];
  logic [WAY_W-1:0] age      [SETS][WAYS];

  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [WRD_W-1:0]  req_word_q;
  logic [31:0]       req_data_q;
  logic              req_rw_q;
  logic [WAY_W-1:0]  victim_q, victim_n;
  logic [LINE_W-1:0] scan_q, scan_n;
  logic              ready_q, ready_n, done_q, done_n, mvalid_q, mvalid_n, mrw_q, mrw_n;
  logic [31:0]       dout_q, dout_n, maddr_q, maddr_n;
  logic [BLK_W-1:0]  mdata_q, mdata_n;
  logic              capture, hit_upd, fill, clr_dirty_victim, clr_dirty_scan;

  logic              hit, vic_found;
  logic [WAY_W-1:0]  hit_way, vic;
  logic [IDX_W-1:0]  scan_set;
  logic [WAY_W-1:0]  scan_way;
  logic              scan_last, mem_done;

  assign scan_set  = scan_q[LINE_W-1 -: IDX_W];
  assign scan_way  = scan_q[WAY_W-1:0];
  assign scan_last = &scan_q;
  // A ready pulse counts only once our own valid pulse has dropped.
  assign mem_done  = bus.mem_req_ready && !mvalid_q;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic       = '0;
    vic_found = 1'b0;
    for (int i = 0; i < WAYS; i++)
      if (valid[req_idx_q][i] && tag_mem[req_idx_q][i] == req_tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid[req_idx_q][i]) begin
        vic       = WAY_W'(i);
        vic_found = 1'b1;
      end
    if (!vic_found)
      for (int i = 0; i < WAYS; i++)
        if (age[req_idx_q][i] == WAY_W'(WAYS - 1)) vic = WAY_W'(i);
  end

  always_comb begin
    state_n          = state;
    ready_n          = ready_q;
    done_n           = 1'b0;
    mvalid_n         = 1'b0;
    mrw_n            = mrw_q;
    maddr_n          = maddr_q;
    mdata_n          = mdata_q;
    dout_n           = dout_q;
    victim_n         = victim_q;
    scan_n           = scan_q;
    capture          = 1'b0;
    hit_upd          = 1'b0;
    fill             = 1'b0;
    clr_dirty_victim = 1'b0;
    clr_dirty_scan   = 1'b0;
    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        if (ready_q && bus.flush_req) begin
          ready_n = 1'b0;
          scan_n  = '0;
          state_n = S_FLUSH_SCAN;
        end else if (ready_q && bus.cpu_req_valid) begin
          ready_n = 1'b0;
          capture = 1'b1;
          state_n = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          hit_upd = 1'b1;
          if (!req_rw_q) dout_n = data_mem[req_idx_q][hit_way][{req_word_q, 5'b0} +: 32];
          state_n = S_IDLE;
        end else begin
          victim_n = vic;
          mvalid_n = 1'b1;
          if (dirty[req_idx_q][vic]) begin
            mrw_n   = 1'b1;
            maddr_n = {tag_mem[req_idx_q][vic], req_idx_q, {OFF_W{1'b0}}};
            mdata_n = data_mem[req_idx_q][vic];
            state_n = S_WRITE_BACK;
          end else begin
            mrw_n   = 1'b0;
            maddr_n = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            state_n = S_ALLOCATE;
          end
        end
      end
      S_WRITE_BACK: if (mem_done) begin
        clr_dirty_victim = 1'b1;
        mvalid_n         = 1'b1;
        mrw_n            = 1'b0;
        maddr_n          = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
        state_n          = S_ALLOCATE;
      end
      S_ALLOCATE: if (mem_done) begin
        fill    = 1'b1;
        state_n = S_COMPARE;
      end
      S_FLUSH_SCAN: begin
        if (dirty[scan_set][scan_way]) begin
          mvalid_n = 1'b1;
          mrw_n    = 1'b1;
          maddr_n  = {tag_mem[scan_set][scan_way], scan_set, {OFF_W{1'b0}}};
          mdata_n  = data_mem[scan_set][scan_way];
          state_n  = S_FLUSH_WB;
        end else if (scan_last) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          scan_n = scan_q + LINE_W'(1);
        end
      end
      S_FLUSH_WB: if (mem_done) begin
        clr_dirty_scan = 1'b1;
        if (scan_last) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          scan_n  = scan_q + LINE_W'(1);
          state_n = S_FLUSH_SCAN;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      mvalid_q   <= 1'b0;
      mrw_q      <= 1'b0;
      maddr_q    <= '0;
      mdata_q    <= '0;
      dout_q     <= '0;
      victim_q   <= '0;
      scan_q     <= '0;
      req_tag_q  <= '0;
      req_idx_q  <= '0;
      req_word_q <= '0;
      req_data_q <= '0;
      req_rw_q   <= 1'b0;
    end else begin
      state    <= state_n;
      ready_q  <= ready_n;
      done_q   <= done_n;
      mvalid_q <= mvalid_n;
      mrw_q    <= mrw_n;
      maddr_q  <= maddr_n;
      mdata_q  <= mdata_n;
      dout_q   <= dout_n;
      victim_q <= victim_n;
      scan_q   <= scan_n;
      if (capture) begin
        req_tag_q  <= bus.cpu_req_addr[31 -: TAG_W];
        req_idx_q  <= bus.cpu_req_addr[OFF_W +: IDX_W];
        req_word_q <= bus.cpu_req_addr[2 +: WRD_W];
        req_data_q <= bus.cpu_req_datain;
        req_rw_q   <= bus.cpu_req_rw;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[req_idx_q][victim_q]  <= req_tag_q;
      data_mem[req_idx_q][victim_q] <= bus.mem_req_datain;
    end else if (hit_upd && req_rw_q) begin
      data_mem[req_idx_q][hit_way][{req_word_q, 5'b0} +: 32] <= req_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_W'(w);
      end
    end else begin
      if (fill) begin
        valid[req_idx_q][victim_q] <= 1'b1;
        dirty[req_idx_q][victim_q] <= 1'b0;
      end
      if (clr_dirty_victim) dirty[req_idx_q][victim_q] <= 1'b0;
      if (clr_dirty_scan)   dirty[scan_set][scan_way]  <= 1'b0;
      if (hit_upd) begin
        if (req_rw_q) dirty[req_idx_q][hit_way] <= 1'b1;
        for (int w = 0; w < WAYS; w++)
          if (WAY_W'(w) == hit_way) age[req_idx_q][w] <= '0;
          else if (age[req_idx_q][w] < age[req_idx_q][hit_way])
            age[req_idx_q][w] <= age[req_idx_q][w] + WAY_W'(1);
      end
    end
  end

  assign bus.cpu_req_dataout = dout_q;
  assign bus.cache_ready     = ready_q;
  assign bus.flush_done      = done_q;
  assign bus.mem_req_addr    = maddr_q;
  assign bus.mem_req_dataout = mdata_q;
  assign bus.mem_req_rw      = mrw_q;
  assign bus.mem_req_valid   = mvalid_q;

`ifdef ASSOC_CACHE_STATS_EN
  logic        refill_q;
  logic [31:0] hits_q, misses_q, wbs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill_q <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      // The COMPARE that follows a fill is a replay, not a new lookup.
      if (fill)         refill_q <= 1'b1;
      else if (capture) refill_q <= 1'b0;
      if (hit_upd && !refill_q && hits_q != '1) hits_q <= hits_q + 32'd1;
      if (state == S_COMPARE && !hit && misses_q != '1) misses_q <= misses_q + 32'd1;
      if ((clr_dirty_victim || clr_dirty_scan) && wbs_q != '1) wbs_q <= wbs_q + 32'd1;
    end
  end

  assign bus.stat_hits       = hits_q;
  assign bus.stat_misses     = misses_q;
  assign bus.stat_writebacks = wbs_q;
`endif
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb/tb_assoc_cache_ctrl.sv - directed vector bench for assoc_cache_ctrl with a latency-programmable memory model
module tb_assoc_cache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assoc_cache_ctrl_if #(.BLK_W(128)) bus ();
  assoc_cache_ctrl #(.WAYS(4), .SETS(512), .BLK_WORDS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int pass_cnt = 0, total_cnt = 0;
  int mem_lat = 3;
  int n_rd = 0, n_wr = 0, done_cnt = 0;
  logic [31:0]  log_addr[$];
  logic         log_rw[$];
  logic [127:0] log_data[$];

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] dout;
    int          cyc;
    int          rd;
    int          wr;
  } vec_t;

  function automatic logic [127:0] fill_block(input logic [31:0] a);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = (32'(k + 1) * 32'h1111_1111) ^ {a[31:13], 13'b0};
    return b;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Memory: logs each request, answers with a one-cycle ready pulse mem_lat cycles after valid drops.
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_req_datain = '0;
    forever begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      if (bus.mem_req_valid) begin
        log_addr.push_back(bus.mem_req_addr);
        log_rw.push_back(bus.mem_req_rw);
        log_data.push_back(bus.mem_req_dataout);
        if (bus.mem_req_rw) n_wr++; else n_rd++;
        repeat (mem_lat) @(posedge clk);
        @(negedge clk);
        bus.mem_req_datain = fill_block(bus.mem_req_addr);
        bus.mem_req_ready  = 1'b1;
      end
    end
  end

  always @(negedge clk) if (bus.flush_done) done_cnt++;

  task automatic cpu_access(input logic [31:0] a, input logic rw, input logic [31:0] d,
                            output logic [31:0] dout, output int cyc);
    int g = 0;
    @(negedge clk);
    while (!bus.cache_ready && g < 10000) begin @(negedge clk); g++; end
    bus.cpu_req_addr   = a;
    bus.cpu_req_rw     = rw;
    bus.cpu_req_datain = d;
    bus.cpu_req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.cache_ready || cyc > 10000) break;
      @(posedge clk);
      cyc++;
    end
    dout = bus.cpu_req_dataout;
  endtask

  task automatic do_flush(output int cyc);
    int g = 0;
    @(negedge clk);
    while (!bus.cache_ready && g < 10000) begin @(negedge clk); g++; end
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1 bus.flush_req = 1'b0;
    cyc = 1;
    forever begin
      @(negedge clk);
      if (bus.flush_done || cyc > 20000) break;
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " ctrl"}, {bus.cache_ready, bus.flush_done, bus.mem_req_rw, bus.mem_req_valid}, 4'b0);
    check({name, " dout"}, bus.cpu_req_dataout, 32'h0);
    check({name, " maddr"}, bus.mem_req_addr, 32'h0);
    check({name, " mdata"}, bus.mem_req_dataout, 128'h0);
  endtask

  vec_t vecs[16];

  initial begin
    logic [31:0] dout;
    int cyc, rd0, wr0, n, d0, base;

    vecs[0]  = '{32'h0000_0010, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 7,  1, 0};
    vecs[1]  = '{32'h0000_0014, 1'b0, 32'h0,         1'b1, 32'h2222_2222, 2,  0, 0};
    vecs[2]  = '{32'h0000_2008, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         7,  1, 0};
    vecs[3]  = '{32'h0000_2008, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 2,  0, 0};
    vecs[4]  = '{32'h0000_0020, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 7,  1, 0};
    vecs[5]  = '{32'h0000_2020, 1'b0, 32'h0,         1'b1, 32'h1111_3111, 7,  1, 0};
    vecs[6]  = '{32'h0000_4020, 1'b0, 32'h0,         1'b1, 32'h1111_5111, 7,  1, 0};
    vecs[7]  = '{32'h0000_6020, 1'b0, 32'h0,         1'b1, 32'h1111_7111, 7,  1, 0};
    vecs[8]  = '{32'h0000_0024, 1'b0, 32'h0,         1'b1, 32'h2222_2222, 2,  0, 0};
    vecs[9]  = '{32'h0000_8020, 1'b0, 32'h0,         1'b1, 32'h1111_9111, 7,  1, 0};
    vecs[10] = '{32'h0000_0020, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 2,  0, 0};
    vecs[11] = '{32'h0000_2020, 1'b0, 32'h0,         1'b1, 32'h1111_3111, 7,  1, 0};
    vecs[12] = '{32'h0000_4000, 1'b0, 32'h0,         1'b1, 32'h1111_5111, 7,  1, 0};
    vecs[13] = '{32'h0000_6000, 1'b0, 32'h0,         1'b1, 32'h1111_7111, 7,  1, 0};
    vecs[14] = '{32'h0000_8000, 1'b0, 32'h0,         1'b1, 32'h1111_9111, 7,  1, 0};
    vecs[15] = '{32'h0000_A000, 1'b0, 32'h0,         1'b1, 32'h1111_B111, 11, 1, 1};

    bus.cpu_req_addr = '0; bus.cpu_req_datain = '0; bus.cpu_req_rw = 1'b0;
    bus.cpu_req_valid = 1'b0; bus.flush_req = 1'b0;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after reset", bus.cache_ready, 1'b1);

    for (int i = 0; i < 16; i++) begin
      rd0 = n_rd; wr0 = n_wr;
      cpu_access(vecs[i].addr, vecs[i].rw, vecs[i].wdata, dout, cyc);
      if (vecs[i].chk) check($sformatf("v%0d dout", i), dout, vecs[i].dout);
      check($sformatf("v%0d cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d mem reads", i), n_rd - rd0, vecs[i].rd);
      check($sformatf("v%0d mem writes", i), n_wr - wr0, vecs[i].wr);
`ifdef ASSOC_CACHE_STATS_EN
      if (i == 1) begin
        check("stat_hits", bus.stat_hits, 32'd1);
        check("stat_misses", bus.stat_misses, 32'd1);
        check("stat_writebacks", bus.stat_writebacks, 32'd0);
      end
`endif
    end

    n = log_addr.size();
    check("wb rw", log_rw[n-2], 1'b1);
    check("wb addr", log_addr[n-2], 32'h0000_2000);
    check("wb word2", log_data[n-2][95:64], 32'hDEAD_BEEF);
    check("wb word0", log_data[n-2][31:0], 32'h1111_3111);
    check("refill after wb rw", log_rw[n-1], 1'b0);
    check("refill after wb addr", log_addr[n-1], 32'h0000_A000);

    cpu_access(32'h0000_0030, 1'b1, 32'hA5A5_0001, dout, cyc);
    cpu_access(32'h0000_0014, 1'b1, 32'h0BAD_F00D, dout, cyc);
    check("write hit cycles", cyc, 2);
    cpu_access(32'h0000_2030, 1'b1, 32'hC0DE_0003, dout, cyc);
    rd0 = n_rd; wr0 = n_wr; d0 = done_cnt; base = log_addr.size();
    do_flush(cyc);
    check("flush writes", n_wr - wr0, 3);
    check("flush reads", n_rd - rd0, 0);
    check("flush done pulses", done_cnt - d0, 1);
    check("flush wr0 addr", log_addr[base], 32'h0000_0010);
    check("flush wr0 data", log_data[base][63:32], 32'h0BAD_F00D);
    check("flush wr1 addr", log_addr[base+1], 32'h0000_0030);
    check("flush wr1 data", log_data[base+1][31:0], 32'hA5A5_0001);
    check("flush wr2 addr", log_addr[base+2], 32'h0000_2030);
    check("flush wr2 data", log_data[base+2][31:0], 32'hC0DE_0003);

    wr0 = n_wr; d0 = done_cnt;
    do_flush(cyc);
    check("clean flush cycles", cyc, 512 * 4 + 1);
    check("clean flush writes", n_wr - wr0, 0);
    check("clean flush pulses", done_cnt - d0, 1);

    rd0 = n_rd; wr0 = n_wr;
    cpu_access(32'h0000_4030, 1'b0, 32'h0, dout, cyc);
    cpu_access(32'h0000_6030, 1'b0, 32'h0, dout, cyc);
    cpu_access(32'h0000_8030, 1'b0, 32'h0, dout, cyc);
    check("post-flush evict reads", n_rd - rd0, 3);
    check("post-flush evict writes", n_wr - wr0, 0);
    check("post-flush evict dout", dout, 32'h1111_9111);

    mem_lat = 10;
    rd0 = n_rd;
    @(negedge clk);
    bus.cpu_req_addr = 32'h0000_4040; bus.cpu_req_rw = 1'b0; bus.cpu_req_valid = 1'b1;
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("alloc read issued", n_rd - rd0, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid-alloc reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after re-reset", bus.cache_ready, 1'b1);
    repeat (20) @(negedge clk);
    check("stray ready ignored", {bus.cache_ready, bus.mem_req_valid}, 2'b10);
    mem_lat = 3;
    rd0 = n_rd;
    cpu_access(32'h0000_4040, 1'b0, 32'h0, dout, cyc);
    check("post-reset miss reads", n_rd - rd0, 1);
    check("post-reset miss dout", dout, 32'h1111_5111);
    check("post-reset miss cycles", cyc, 7);
    cpu_access(32'h0000_0014, 1'b0, 32'h0, dout, cyc);
    check("valid cleared dout", dout, 32'h2222_2222);
    check("valid cleared cycles", cyc, 7);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/assoc_cache_ctrl.md
# assoc_cache_ctrl

Parametrised N-way set-associative, write-back, write-allocate cache controller with true-LRU replacement and a full-cache flush sequencer. It sits between the CPU request port and the main-memory block port, replacing the fixed 2-way controller. Way count, set count and block size are generics. Valid/dirty/LRU state is reset in hardware; tag and data arrays are not.

## Interface
- `WAYS`, 4: associativity; power of two, 2..8.
- `SETS`, 512: sets per way; power of two.
- `BLK_WORDS`, 4: 32-bit words per block; power of two, 2..16.
- Derived: `OFF_W`=log2(BLK_WORDS)+2, `IDX_W`=log2(SETS), `TAG_W`=32-IDX_W-OFF_W, `BLK_W`=32*BLK_WORDS.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req_addr`  in  32  byte address; `[1:0]` ignored.
- `cpu_req_datain`  in  32  write word.
- `cpu_req_rw`  in  1  1=write, 0=read.
- `cpu_req_valid`  in  1  request strobe.
- `cpu_req_dataout`  out  32  read word, registered.
- `cache_ready`  out  1  high = idle, accepting; falling edge = request taken; rising edge = request complete.
- `flush_req`  in  1  start write-back of all dirty lines.
- `flush_done`  out  1  one-cycle pulse at flush end.
- `mem_req_addr`  out  32  block-aligned address (low OFF_W bits zero).
- `mem_req_dataout`  out  BLK_W  write-back block.
- `mem_req_datain`  in  BLK_W  fill block, valid when `mem_req_ready`=1.
- `mem_req_rw`  out  1  1=write, 0=read.
- `mem_req_valid`  out  1  one-cycle request pulse.
- `mem_req_ready`  in  1  one-cycle completion pulse.

## Operation
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB.
- Reset values:
  - All outputs 0.
  - All valid and dirty bits 0.
  - Way i age = i.
  - State IDLE.
  - `cache_ready` rises the first clock after reset release.
- IDLE:
  - `flush_req` has priority over `cpu_req_valid`.
  - A CPU request is captured (address, data, rw) when `cpu_req_valid` && `cache_ready`. Go to COMPARE.
- COMPARE:
  - Hit if any way has valid=1 and a matching tag. At most one way may hit.
  - Read hit: the addressed word goes to `cpu_req_dataout`. Go to IDLE.
  - Write hit: the addressed word is merged into the block and dirty is set. Go to IDLE.
  - Miss, victim selection: the lowest-index invalid way; otherwise the way with age WAYS-1.
  - Miss with a dirty victim: issue a memory write of the victim's old tag, index and block. Go to WRITE_BACK.
  - Miss with a clean victim: issue a memory read of the requested block. Go to ALLOCATE.
- WRITE_BACK:
  - On `mem_req_ready`: clear the victim's dirty bit, issue a read of the requested block, go to ALLOCATE.
- ALLOCATE:
  - On `mem_req_ready`: write `mem_req_datain` into the victim, set valid=1, dirty=0, tag=new tag. Return to COMPARE, which now hits.
  - A write miss therefore merges the CPU word after the fill.
- LRU update on every hit, for the accessed way w with age a:
  - Ways with age < a increment.
  - w becomes 0.
  - Ages within a set stay a permutation of 0..WAYS-1.
- Flush:
  - Scan set 0..SETS-1, way 0..WAYS-1, one line per cycle in FLUSH_SCAN.
  - A dirty line issues a memory write and waits in FLUSH_WB for `mem_req_ready`. It then clears dirty and resumes the scan at the next line.
  - Valid bits and ages are kept.
  - After the last line, pulse `flush_done` and return to IDLE.
- `cpu_req_valid` is ignored while `cache_ready`=0.

## Timing
- Read/write hit: request sampled at edge T. `cache_ready`=0 from T. COMPARE at T+1. Data and `cache_ready`=1 at T+2.
- Memory handshake:
  - `mem_req_valid` is high for exactly one cycle.
  - Address, rw and data are held stable until `mem_req_ready`.
  - `mem_req_ready` is honoured only after `mem_req_valid` has dropped.
  - Memory latency is unbounded; no timeout.
- Clean miss with memory latency L: response at T+2+L+2.
- Dirty miss: two sequential memory transactions.
- Flush of a clean cache: SETS*WAYS+1 cycles until `flush_done`.
- `rst_n` asserted mid-transaction:
  - Immediate return to IDLE; outputs go to their reset values.
  - Dirty data is lost.
  - An in-flight `mem_req_ready` after reset is ignored.

## Configuration
- `ASSOC_CACHE_STATS_EN` defined:
  - Adds 32-bit outputs `stat_hits`, `stat_misses`, `stat_writebacks`, each reset to 0 and saturating at 0xFFFFFFFF.
  - Each is incremented once per first-pass COMPARE hit, first-pass COMPARE miss, and completed memory write (including flush writes) respectively.
  - The re-entry COMPARE after ALLOCATE is not counted.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then read 0x0000_0010 with memory returning block 0x4444…_1111 → miss; one read at 0x0000_0010; `cpu_req_dataout`=0x1111_1111 (word 0). Re-read of 0x0000_0014 hits in 2 cycles with word 1.
- WAYS=4: fill 5 distinct tags into index 0, reading tag 0 before the 5th → way holding tag 1 (age 3) is evicted; tag 0 remains hit.
- Write 0xDEAD_BEEF to 0x0000_2008 (miss), then force eviction of that line → memory write at 0x0000_2000 containing 0xDEAD_BEEF in word 2, preceding the new read.
- `flush_req` with 3 dirty lines → exactly 3 memory writes in ascending set/way order, one `flush_done` pulse; subsequent evictions issue no writes.
- Deassert `rst_n` during ALLOCATE → all outputs 0; after release, same address misses again (valid cleared).
- `ASSOC_CACHE_STATS_EN`: the sequence of scenario 1 → `stat_hits`=1, `stat_misses`=1, `stat_writebacks`=0.
